// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake head logic.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
        logic [1:0] opp;
        case (dir)
            DIR_UP:    opp = DIR_DOWN;
            DIR_DOWN:  opp = DIR_UP;
            DIR_LEFT:  opp = DIR_RIGHT;
            DIR_RIGHT: opp = DIR_LEFT;
            default:   opp = DIR_LEFT;
        endcase
        return opp;
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Step pacing counter: counts 0..TICK_DIV-1 while run is high, holds otherwise.
// tick is combinational and marks the terminal count of a running timer.
module snake_step_timer #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_r;

    // Step counter with wrap at the terminal value; frozen while not running
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= {CW{1'b0}};
        end else if (run) begin
            if (count_r == LAST) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = run && (count_r == LAST);

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head motion: direction arbitration, reversal rejection and paced head stepping.
// Optional SNAKE_WALL_KILL_EN: leaving the grid sets a sticky game_over instead of wrapping.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int XW       = 6,
    parameter int YW       = 5,
    parameter int TICK_DIV = 5_000_000,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          enable,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    heading,
    output logic          step,
    output logic          game_over
);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    logic [XW-1:0] head_x_r;
    logic [YW-1:0] head_y_r;
    logic [1:0]    heading_r;
    logic [1:0]    pending_r;
    logic          step_r;

    logic          go_s;
    logic          hit_s;
    logic          run_s;
    logic          tick_s;
    logic          req_valid_s;
    logic          req_ok_s;
    logic [1:0]    req_dir_s;
    logic [XW-1:0] next_x_s;
    logic [YW-1:0] next_y_s;

    assign run_s = enable && !go_s;

    snake_step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .run    (run_s),
        .tick   (tick_s)
    );

    // Priority-resolve request pulses; reversals are judged against the committed heading only
    always_comb begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_RIGHT;
        if (up) begin
            req_dir_s = DIR_UP;
        end else if (down) begin
            req_dir_s = DIR_DOWN;
        end else if (left) begin
            req_dir_s = DIR_LEFT;
        end else if (right) begin
            req_dir_s = DIR_RIGHT;
        end else begin
            req_valid_s = 1'b0;
        end
        req_ok_s = req_valid_s && (req_dir_s != opposite_dir(heading_r));
    end

    // Next head cell in the pending direction, wrapping at the grid edges without overflow
    always_comb begin
        next_x_s = head_x_r;
        next_y_s = head_y_r;
        case (pending_r)
            DIR_UP:   next_y_s = (head_y_r == {YW{1'b0}}) ? Y_MAX : head_y_r - YW'(1);
            DIR_DOWN: next_y_s = (head_y_r == Y_MAX) ? {YW{1'b0}} : head_y_r + YW'(1);
            DIR_LEFT: next_x_s = (head_x_r == {XW{1'b0}}) ? X_MAX : head_x_r - XW'(1);
            default:  next_x_s = (head_x_r == X_MAX) ? {XW{1'b0}} : head_x_r + XW'(1);
        endcase
    end

`ifdef SNAKE_WALL_KILL_EN
    logic game_over_r;

    // A move is fatal when it would cross the edge the pending direction points at
    always_comb begin
        hit_s = 1'b0;
        case (pending_r)
            DIR_UP:   hit_s = (head_y_r == {YW{1'b0}});
            DIR_DOWN: hit_s = (head_y_r == Y_MAX);
            DIR_LEFT: hit_s = (head_x_r == {XW{1'b0}});
            default:  hit_s = (head_x_r == X_MAX);
        endcase
    end

    // Sticky wall-hit flag, cleared only by reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            game_over_r <= 1'b0;
        end else if (tick_s && hit_s) begin
            game_over_r <= 1'b1;
        end else begin
            game_over_r <= game_over_r;
        end
    end

    assign go_s = game_over_r;
`else
    assign hit_s = 1'b0;
    assign go_s  = 1'b0;
`endif

    // Head, heading and pending state; the request seen in a terminal cycle feeds the next step
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head_x_r  <= XW'(START_X);
            head_y_r  <= YW'(START_Y);
            heading_r <= DIR_RIGHT;
            pending_r <= DIR_RIGHT;
            step_r    <= 1'b0;
        end else begin
            step_r <= 1'b0;
            if (tick_s && !hit_s) begin
                heading_r <= pending_r;
                head_x_r  <= next_x_s;
                head_y_r  <= next_y_s;
                step_r    <= 1'b1;
            end else begin
                heading_r <= heading_r;
            end
            if (req_ok_s && !go_s) begin
                pending_r <= req_dir_s;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign head_x    = head_x_r;
    assign head_y    = head_y_r;
    assign heading   = heading_r;
    assign step      = step_r;
    assign game_over = go_s;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Scoreboard bench for snake_head_stepper: a cycle-level reference model predicts each
// step (cell, heading, arrival cycle); a negedge monitor compares whenever step fires.
module tb_snake_head_stepper;

    localparam int TICK_DIV = 4;
    localparam int GRID_W   = 8;
    localparam int GRID_H   = 6;
    localparam int XW       = 6;
    localparam int YW       = 5;
    localparam int START_X  = 3;
    localparam int START_Y  = 2;

    logic          clock  = 1'b0;
    logic          resetn = 1'b1;
    logic          enable = 1'b0;
    logic          up     = 1'b0;
    logic          down   = 1'b0;
    logic          left   = 1'b0;
    logic          right  = 1'b0;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [1:0]    heading;
    logic          step;
    logic          game_over;

    snake_head_stepper #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .XW       (XW),
        .YW       (YW),
        .TICK_DIV (TICK_DIV),
        .START_X  (START_X),
        .START_Y  (START_Y)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .enable    (enable),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .head_x    (head_x),
        .head_y    (head_y),
        .heading   (heading),
        .step      (step),
        .game_over (game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int h;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: position, committed heading, pending request, enabled-cycle phase
    int m_x, m_y, m_h, m_p, m_t;
    bit m_go;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_x  = START_X;
        m_y  = START_Y;
        m_h  = 3;
        m_p  = 3;
        m_t  = 0;
        m_go = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs and advance the model to match the coming rising edge
    task automatic cycle(input bit en, input bit u, input bit d, input bit l, input bit r);
        int   req;
        bit   acc;
        bit   go_before;
        int   nx, ny;
        exp_t e;
        @(negedge clock);
        enable = en; up = u; down = d; left = l; right = r;
        req = u ? 0 : d ? 1 : l ? 2 : r ? 3 : -1;
        acc = (req >= 0) && (req != (m_h ^ 1));
        go_before = m_go;
        if (!m_go && en) begin
            if (m_t == TICK_DIV - 1) begin
                m_t = 0;
                nx = m_x + ((m_p == 3) ? 1 : 0) - ((m_p == 2) ? 1 : 0);
                ny = m_y + ((m_p == 1) ? 1 : 0) - ((m_p == 0) ? 1 : 0);
`ifdef SNAKE_WALL_KILL_EN
                if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
                    m_go = 1'b1;
                end else begin
                    m_x = nx; m_y = ny; m_h = m_p;
                    e.x = m_x; e.y = m_y; e.h = m_h; e.due = cyc + 1;
                    exp_q.push_back(e);
                end
`else
                m_x = (nx + GRID_W) % GRID_W;
                m_y = (ny + GRID_H) % GRID_H;
                m_h = m_p;
                e.x = m_x; e.y = m_y; e.h = m_h; e.due = cyc + 1;
                exp_q.push_back(e);
`endif
            end else begin
                m_t++;
            end
        end
        if (acc && !go_before) m_p = req;
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) cycle(en, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every step must match the oldest prediction, on the predicted cycle
    always @(negedge clock) begin
        exp_t e;
        if (resetn) begin
            if (step) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_step: got step=1 expected no step (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("step_cycle", cyc, e.due);
                    check("head_x", int'(head_x), e.x);
                    check("head_y", int'(head_y), e.y);
                    check("heading", int'(heading), e.h);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_step: got no step expected step at cycle %0d (now %0d)", e.due, cyc);
            end
        end
    end

    initial begin
        #1 resetn = 1'b0;
        #1;
        check("reset_head_x", int'(head_x), START_X);
        check("reset_head_y", int'(head_y), START_Y);
        check("reset_heading", int'(heading), 3);
        check("reset_step", int'(step), 0);
        check("reset_game_over", int'(game_over), 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Free run to the right edge and wrap
        idle(20, 1'b1);
        // Reversal dropped, then a legal turn up
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(8, 1'b1);
        // Simultaneous up+left: up wins
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1);
        // Heading up: left then right, last legal request wins
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b1);
        // Enable dropped mid-count
        idle(2, 1'b1);
        idle(10, 1'b0);
        idle(9, 1'b1);

        // Randomized play
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset in the middle of a count
        for (int i = 0; i < 4 * TICK_DIV && m_t != 2; i++) idle(1, 1'b1);
        @(posedge clock);
        #2;
        enable = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        resetn = 1'b0;
        #1;
        check("async_reset_head_x", int'(head_x), START_X);
        check("async_reset_head_y", int'(head_y), START_Y);
        check("async_reset_heading", int'(heading), 3);
        check("async_reset_step", int'(step), 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        idle(5, 1'b1);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end
        idle(2 * TICK_DIV, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        check("game_over_final", int'(game_over), int'(m_go));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
